// File: rtl/bmf_pkg.sv
// Shared defaults and helpers for the BMF decoder slice.
// popcount is sized to a fixed maximum width; callers zero-extend into it.
package bmf_pkg;

  localparam int BMF_K_W_DEF      = 6;
  localparam int BMF_N_OUT_DEF    = 7;
  localparam int BMF_CNT_W_DEF    = 16;
  localparam int BMF_POPCNT_MAX_W = 64;
  localparam int BMF_POPCNT_W     = $clog2(BMF_POPCNT_MAX_W) + 1;

  function automatic logic [BMF_POPCNT_W-1:0] popcount(input logic [BMF_POPCNT_MAX_W-1:0] v);
    logic [BMF_POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < BMF_POPCNT_MAX_W; i++) begin
      c = c + BMF_POPCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bmf_or_plane.sv
// Masked-OR decode plane: y[j] is set when any latent bit selected by row j is set.
// Purely combinational, no flow control.
module bmf_or_plane
  import bmf_pkg::*;
#(
  parameter int K_W   = BMF_K_W_DEF,
  parameter int N_OUT = BMF_N_OUT_DEF
) (
  input  logic [K_W-1:0]            k,
  input  logic [N_OUT-1:0][K_W-1:0] h,
  output logic [N_OUT-1:0]          y
);

  always_comb begin
    y = '0;
    for (int j = 0; j < N_OUT; j++) begin
      y[j] = |(k & h[j]);
    end
  end

endmodule

// File: rtl/bmf_decode_pipe.sv
// BMF decoder stage: 1-cycle registered decode with programmable H rows and saturating error stats.
// Single output register; in_ready = ~out_valid | out_ready gives full throughput and holds out_y under stall.
module bmf_decode_pipe
  import bmf_pkg::*;
#(
  parameter int K_W   = BMF_K_W_DEF,
  parameter int N_OUT = BMF_N_OUT_DEF,
  parameter int CNT_W = BMF_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(N_OUT)-1:0] cfg_row,
  input  logic [K_W-1:0]           cfg_mask,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K_W-1:0]           in_k,
  input  logic [N_OUT-1:0]         in_exact,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT-1:0]         out_y,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         samp_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         err_bits
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int SUM_W = ((CNT_W > BMF_POPCNT_W) ? CNT_W : BMF_POPCNT_W) + 1;

  logic [N_OUT-1:0][K_W-1:0] h;
  logic [N_OUT-1:0]          y_dec;
  logic [N_OUT-1:0]          exact_q;
  logic                      in_acc;
  logic                      out_hs;
  logic                      mismatch;
  logic [BMF_POPCNT_W-1:0]   miss_bits;
  logic [SUM_W-1:0]          bits_sum;
  logic [CNT_W-1:0]          bits_next;

  bmf_or_plane #(
    .K_W   (K_W),
    .N_OUT (N_OUT)
  ) u_plane (
    .k (in_k),
    .h (h),
    .y (y_dec)
  );

  assign in_ready  = ~out_valid | out_ready;
  assign in_acc    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign mismatch  = (out_y != exact_q);
  assign miss_bits = popcount(BMF_POPCNT_MAX_W'(out_y ^ exact_q));
  // Widened sum so the clamp sees the true total even when CNT_W is narrower than a popcount.
  assign bits_sum  = SUM_W'(err_bits) + SUM_W'(miss_bits);
  assign bits_next = (bits_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bits_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
    end else if (cfg_we && (32'(cfg_row) < N_OUT)) begin
      h[cfg_row] <= cfg_mask;
    end
  end

  // y_dec reads h before this edge's write lands, so a same-cycle write only affects later samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      exact_q   <= '0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
      out_y     <= y_dec;
      exact_q   <= in_exact;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      samp_cnt <= '0;
      err_cnt  <= '0;
      err_bits <= '0;
    end else if (out_hs) begin
      if (samp_cnt != CNT_MAX) begin
        samp_cnt <= samp_cnt + CNT_W'(1);
      end
      if (mismatch && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      err_bits <= bits_next;
    end
  end

endmodule

// File: tb/tb_bmf_decode_pipe.sv
// Directed bench for bmf_decode_pipe: a behavioural model checked every cycle plus literal spot checks.
// Two instances share stimulus; the CNT_W=4 copy exercises counter saturation.
module tb_bmf_decode_pipe;

  localparam int K_W   = 6;
  localparam int N_OUT = 7;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_row;
  logic [5:0] cfg_mask;
  logic       in_valid;
  logic [5:0] in_k;
  logic [6:0] in_exact;
  logic       out_ready;
  logic       stat_clr;

  logic        in_ready, out_valid;
  logic [6:0]  out_y;
  logic [15:0] samp_cnt, err_cnt, err_bits;
  logic        in_ready4, out_valid4;
  logic [6:0]  out_y4;
  logic [3:0]  samp4, err4, bits4;

  bmf_decode_pipe dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_mask(cfg_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k), .in_exact(in_exact),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .stat_clr(stat_clr),
    .samp_cnt(samp_cnt), .err_cnt(err_cnt), .err_bits(err_bits)
  );

  bmf_decode_pipe #(.K_W(6), .N_OUT(7), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_mask(cfg_mask),
    .in_valid(in_valid), .in_ready(in_ready4), .in_k(in_k), .in_exact(in_exact),
    .out_valid(out_valid4), .out_ready(out_ready), .out_y(out_y4), .stat_clr(stat_clr),
    .samp_cnt(samp4), .err_cnt(err4), .err_bits(bits4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: H table, one-slot output holder, unbounded totals clamped at compare time.
  logic [5:0] mh [N_OUT];
  logic       mv = 1'b0;
  logic [6:0] my = '0;
  logic [6:0] mx = '0;
  int         tot_s = 0, tot_e = 0, tot_b = 0;
  logic       m_hs, m_acc;

  function automatic logic [6:0] mdec(input logic [5:0] k);
    logic [6:0] y;
    y = '0;
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < K_W; i++)
        if (k[i] && mh[j][i]) y[j] = 1'b1;
    return y;
  endfunction

  function automatic int sat(input int v, input int mx_v);
    return (v > mx_v) ? mx_v : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_OUT; r++) mh[r] = '0;
      mv = 1'b0; my = '0; mx = '0;
      tot_s = 0; tot_e = 0; tot_b = 0;
    end else begin
      m_hs  = mv && out_ready;
      m_acc = in_valid && (!mv || out_ready);
      if (stat_clr) begin
        tot_s = 0; tot_e = 0; tot_b = 0;
      end else if (m_hs) begin
        tot_s = tot_s + 1;
        if (my != mx) tot_e = tot_e + 1;
        tot_b = tot_b + $countones(my ^ mx);
      end
      if (m_acc) begin
        my = mdec(in_k); mx = in_exact; mv = 1'b1;
      end else if (out_ready) begin
        mv = 1'b0;
      end
      if (cfg_we && cfg_row < 3'(N_OUT)) mh[cfg_row] = cfg_mask;
    end
  end

  always begin
    @(negedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(mv));
    check("in_ready", 64'(in_ready), 64'(!mv || out_ready));
    check("out_y", 64'(out_y), 64'(my));
    check("samp_cnt", 64'(samp_cnt), 64'(sat(tot_s, 65535)));
    check("err_cnt", 64'(err_cnt), 64'(sat(tot_e, 65535)));
    check("err_bits", 64'(err_bits), 64'(sat(tot_b, 65535)));
    check("out_valid4", 64'(out_valid4), 64'(mv));
    check("in_ready4", 64'(in_ready4), 64'(!mv || out_ready));
    check("out_y4", 64'(out_y4), 64'(my));
    check("samp4", 64'(samp4), 64'(sat(tot_s, 15)));
    check("err4", 64'(err4), 64'(sat(tot_e, 15)));
    check("bits4", 64'(bits4), 64'(sat(tot_b, 15)));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [5:0] hrow [N_OUT] = '{6'b110010, 6'b000100, 6'b100000, 6'b111110,
                               6'b110000, 6'b101000, 6'b100000};

  function automatic logic [6:0] hdec(input logic [5:0] k);
    logic [6:0] y;
    y = '0;
    for (int j = 0; j < N_OUT; j++) y[j] = |(k & hrow[j]);
    return y;
  endfunction

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_mask = '0;
    in_valid = 1'b0; in_k = '0; in_exact = '0; out_ready = 1'b0; stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_samp", 64'(samp_cnt), 64'd0);

    for (int r = 0; r < N_OUT; r++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_row = 3'(r); cfg_mask = hrow[r];
    end
    @(negedge clk);
    cfg_we = 1'b0;

    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1; in_k = 6'(k); in_exact = hdec(6'(k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("sweep_samp", 64'(samp_cnt), 64'd64);
    check("sweep_err", 64'(err_cnt), 64'd0);
    check("sweep_samp4", 64'(samp4), 64'd15);

    in_valid = 1'b1; in_k = 6'b000010; in_exact = 7'b0000000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("k2_out_y", 64'(out_y), 64'(7'b0001001));
    @(negedge clk);
    #1;
    check("k2_err_cnt", 64'(err_cnt), 64'd1);
    check("k2_err_bits", 64'(err_bits), 64'd2);
    check("k2_samp", 64'(samp_cnt), 64'd65);

    out_ready = 1'b0;
    in_valid = 1'b1; in_k = 6'b100000; in_exact = 7'b1111101;
    @(negedge clk);
    in_k = 6'b000001;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_y", 64'(out_y), 64'(7'b1111101));
      check("stall_samp", 64'(samp_cnt), 64'd65);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("release_samp", 64'(samp_cnt), 64'd66);
    check("release_err", 64'(err_cnt), 64'd1);

    in_valid = 1'b1; in_k = 6'b000010; in_exact = 7'b0000000;
    cfg_we = 1'b1; cfg_row = 3'd0; cfg_mask = 6'b000000;
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    check("samecyc_y0_old", 64'(out_y[0]), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("samecyc_y0_new", 64'(out_y[0]), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_k = 6'(i + 1); in_exact = ~mdec(6'(i + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("sat_samp4", 64'(samp4), 64'd15);
    check("sat_err4", 64'(err4), 64'd15);
    check("sat_bits4", 64'(bits4), 64'd15);
    check("sat_samp", 64'(samp_cnt), 64'd88);

    in_valid = 1'b1; in_k = 6'b000001; in_exact = 7'b1111111;
    @(negedge clk);
    in_valid = 1'b0; stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("clr_samp", 64'(samp_cnt), 64'd0);
    check("clr_err4", 64'(err4), 64'd0);
    check("clr_bits", 64'(err_bits), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_k = 6'b111111; in_exact = 7'b0000000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("prerst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_out_y", 64'(out_y), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_samp", 64'(samp_cnt), 64'd0);
    cfg_we = 1'b1; cfg_row = 3'd7; cfg_mask = 6'b111111; out_ready = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b1; in_k = 6'b111111; in_exact = 7'b0000000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("h_zero_out_y", 64'(out_y), 64'd0);
    @(negedge clk);
    #1;
    check("post_samp", 64'(samp_cnt), 64'd1);
    check("post_err", 64'(err_cnt), 64'd0);

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
